// File: rtl/glyph_plotter_if.sv
// Pixel-write bus between the glyph plotter and the framebuffer write port.
// The plotter drives one pixel (x, y, colour) qualified by plot; the
// framebuffer accepts it in any cycle where plot_ready is high.
interface glyph_plotter_if #(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOUR_W = 3
);
  logic [X_W-1:0]      x;
  logic [Y_W-1:0]      y;
  logic [COLOUR_W-1:0] colour;
  logic                plot;
  logic                plot_ready;

  modport master (output x, output y, output colour, output plot, input plot_ready);
  modport slave  (input x, input y, input colour, input plot, output plot_ready);
endinterface

// File: rtl/glyph_plotter.sv
// glyph_plotter: rasterises one 8x16 glyph bitmap into 128 single-pixel
// writes, row-major, at the character cell (char_col, char_row).
// Optional build macro TRANSPARENT_BG_EN: when defined, clear glyph bits
// are skipped (no write) and the scan moves on one pixel per cycle.
module glyph_plotter #(
  parameter int COLS     = 20,
  parameter int ROWS     = 7,
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOUR_W = 3
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                start,
  input  logic [127:0]        glyph,
  input  logic [4:0]          char_col,
  input  logic [2:0]          char_row,
  input  logic [COLOUR_W-1:0] fg,
  input  logic [COLOUR_W-1:0] bg,
  output logic                busy,
  output logic                done,
  output logic                err,
  glyph_plotter_if.master     pix
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DRAW = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next_state;

  // Scan position: r_pix[6:3] is glyph row r, r_pix[2:0] is glyph column c.
  logic [6:0]          r_pix;
  logic [127:0]        r_glyph;
  logic [4:0]          r_col;
  logic [2:0]          r_row;
  logic [COLOUR_W-1:0] r_fg;
  logic [COLOUR_W-1:0] r_bg;

  logic [X_W-1:0]      r_x;
  logic [Y_W-1:0]      r_y;
  logic [COLOUR_W-1:0] r_colour;
  logic                r_plot;
  logic                r_busy;
  logic                r_done;
  logic                r_err;

  logic                w_in_range;
  logic                w_accept;
  logic                w_adv;
  logic                w_last;

  // Pixel about to be presented (either pixel 0 of a new draw or the next one).
  logic [6:0]          w_ld_pos;
  logic [6:0]          w_ld_idx;
  logic [127:0]        w_src_glyph;
  logic [4:0]          w_src_col;
  logic [2:0]          w_src_row;
  logic [COLOUR_W-1:0] w_src_fg;
  logic [COLOUR_W-1:0] w_src_bg;
  logic                w_ld_bit;
  logic                w_ld_plot;
  logic [X_W-1:0]      w_ld_x;
  logic [Y_W-1:0]      w_ld_y;
  logic [COLOUR_W-1:0] w_ld_colour;

  logic [6:0]          w_pix_d;
  logic [X_W-1:0]      w_x_d;
  logic [Y_W-1:0]      w_y_d;
  logic [COLOUR_W-1:0] w_colour_d;
  logic                w_plot_d;
  logic                w_busy_d;
  logic                w_done_d;
  logic                w_err_d;

  assign w_in_range = (char_col < 5'(COLS)) && (char_row < 3'(ROWS));
  assign w_accept   = (r_state == S_IDLE) && start && w_in_range;
  // A skipped (plot=0) pixel advances without waiting for the framebuffer.
  assign w_adv      = (r_state == S_DRAW) && (!r_plot || pix.plot_ready);
  assign w_last     = (r_pix == 7'd127);

  // Pick the source of the next pixel: live inputs on acceptance, latched copy while drawing.
  always_comb begin
    if (r_state == S_IDLE) begin
      w_ld_pos    = 7'd0;
      w_src_glyph = glyph;
      w_src_col   = char_col;
      w_src_row   = char_row;
      w_src_fg    = fg;
      w_src_bg    = bg;
    end else begin
      w_ld_pos    = r_pix + 7'd1;
      w_src_glyph = r_glyph;
      w_src_col   = r_col;
      w_src_row   = r_row;
      w_src_fg    = r_fg;
      w_src_bg    = r_bg;
    end
  end

  // Bit 127 is the top-left pixel, so the bit index is 127 - pos, i.e. ~pos.
  assign w_ld_idx    = ~w_ld_pos;
  assign w_ld_bit    = w_src_glyph[w_ld_idx];
  assign w_ld_colour = w_ld_bit ? w_src_fg : w_src_bg;
  assign w_ld_x      = X_W'({w_src_col, 3'b000}) + X_W'(w_ld_pos[2:0]);
  assign w_ld_y      = Y_W'({w_src_row, 4'b0000}) + Y_W'(w_ld_pos[6:3]);

`ifdef TRANSPARENT_BG_EN
  assign w_ld_plot = w_ld_bit;
`else
  assign w_ld_plot = 1'b1;
`endif

  // State, scan counter, latched request and registered outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state  <= S_IDLE;
      r_pix    <= 7'd0;
      r_glyph  <= 128'd0;
      r_col    <= 5'd0;
      r_row    <= 3'd0;
      r_fg     <= '0;
      r_bg     <= '0;
      r_x      <= '0;
      r_y      <= '0;
      r_colour <= '0;
      r_plot   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_pix    <= w_pix_d;
      if (w_accept) begin
        r_glyph <= glyph;
        r_col   <= char_col;
        r_row   <= char_row;
        r_fg    <= fg;
        r_bg    <= bg;
      end
      r_x      <= w_x_d;
      r_y      <= w_y_d;
      r_colour <= w_colour_d;
      r_plot   <= w_plot_d;
      r_busy   <= w_busy_d;
      r_done   <= w_done_d;
      r_err    <= w_err_d;
    end
  end

  // Next-state decode: starts are only honoured in IDLE; FIN lasts one cycle.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next_state = S_DRAW;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_DRAW: begin
        if (w_adv && w_last) begin
          w_next_state = S_FIN;
        end else begin
          w_next_state = S_DRAW;
        end
      end
      S_FIN:   w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Output decode: compute the values the output registers take at the next edge.
  always_comb begin
    w_pix_d    = r_pix;
    w_x_d      = r_x;
    w_y_d      = r_y;
    w_colour_d = r_colour;
    w_plot_d   = r_plot;
    w_busy_d   = r_busy;
    w_done_d   = 1'b0;
    w_err_d    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (w_in_range) begin
            w_pix_d    = w_ld_pos;
            w_x_d      = w_ld_x;
            w_y_d      = w_ld_y;
            w_colour_d = w_ld_colour;
            w_plot_d   = w_ld_plot;
            w_busy_d   = 1'b1;
          end else begin
            w_err_d    = 1'b1;
          end
        end else begin
          w_err_d = 1'b0;
        end
      end
      S_DRAW: begin
        if (w_adv) begin
          if (w_last) begin
            w_plot_d = 1'b0;
            w_busy_d = 1'b0;
            w_done_d = 1'b1;
          end else begin
            w_pix_d    = w_ld_pos;
            w_x_d      = w_ld_x;
            w_y_d      = w_ld_y;
            w_colour_d = w_ld_colour;
            w_plot_d   = w_ld_plot;
          end
        end else begin
          w_plot_d = r_plot;
        end
      end
      S_FIN: begin
        w_plot_d = 1'b0;
        w_busy_d = 1'b0;
      end
      default: begin
        w_plot_d = 1'b0;
        w_busy_d = 1'b0;
      end
    endcase
  end

  assign pix.x      = r_x;
  assign pix.y      = r_y;
  assign pix.colour = r_colour;
  assign pix.plot   = r_plot;
  assign busy       = r_busy;
  assign done       = r_done;
  assign err        = r_err;

endmodule

// File: doc/glyph_plotter.md
Name: glyph_plotter

Overview:
Consumer side of the character glyph path. It takes a 128-bit 8x16 glyph bitmap and a character-cell position, and rasterises the glyph into a stream of single-pixel writes for the VGA pixel-write adapter. The block sits between the text buffer/cursor controller, which issues one draw request per character, and the framebuffer write port. Cells are arranged 8 px wide by 16 px tall on a 160x120 screen.

Parameters:
COLS, 20, number of character columns (160/8)
ROWS, 7, number of character rows (floor(120/16))
X_W, 8, width of pixel x coordinate
Y_W, 7, width of pixel y coordinate
COLOUR_W, 3, width of colour word

Ports:
clk  in  1  system clock, all logic on rising edge
resetn  in  1  synchronous reset, active-low
start  in  1  draw request; accepted only in IDLE
glyph  in  128  bitmap; bit 127 = top-left pixel; row r col c = bit 127-(8r+c); col 0 = leftmost
char_col  in  5  cell column, 0..COLS-1
char_row  in  3  cell row, 0..ROWS-1
fg  in  COLOUR_W  colour for set bits
bg  in  COLOUR_W  colour for clear bits
plot_ready  in  1  framebuffer accepts the presented pixel this cycle
x  out  X_W  pixel x = char_col*8 + c
y  out  Y_W  pixel y = char_row*16 + r
colour  out  COLOUR_W  pixel colour
plot  out  1  pixel write valid
busy  out  1  high while drawing
done  out  1  one-cycle pulse on completion
err  out  1  one-cycle pulse on rejected request

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low. Ports are clk and resetn.
- Reset values: x=0, y=0, colour=0, plot=0, busy=0, done=0, err=0; state=IDLE; scan counters r=0, c=0.
- An edge with resetn low aborts any draw in progress. No further plot is issued and done does not pulse.
- FSM states: IDLE, DRAW, FIN.
- IDLE, start=1, position in range:
  - latch glyph, fg, bg, char_col, char_row.
  - set r=c=0, go to DRAW.
  - next cycle: busy=1 and the first pixel (r=0, c=0) is presented.
- IDLE, start=1, char_col>=COLS or char_row>=ROWS: err=1 for one cycle, stay in IDLE, no plot.
- DRAW: the presented pixel holds x, y, colour and plot stable until plot_ready=1.
- On acceptance, advance to the next pixel:
  - c increments; at c=7 it wraps to 0 and r increments.
  - row-major scan, 128 pixels.
- Acceptance of pixel (r=15, c=7): go to FIN, plot=0.
- FIN: done=1 and busy=0 for exactly one cycle, then IDLE.
- A start in FIN or DRAW is ignored: not queued, no err. Latched inputs are immune to input changes during a draw.
- Latency with plot_ready held high: start at cycle 0, pixels at cycles 1..128, done at cycle 129. A new start is accepted at cycle 130.
- Arithmetic: x = {char_col,3'b0}+c and y = {char_row,4'b0}+r, zero-extended to X_W/Y_W. No overflow is possible for in-range cells.
- colour = glyph bit ? fg : bg. The all-zero glyph (space) still plots 128 bg pixels.

Optional Feature:
TRANSPARENT_BG_EN
- Defined: pixels whose glyph bit is 0 are skipped. plot stays 0 and the scan advances one pixel per cycle regardless of plot_ready. Set pixels behave as normal. With ready high, done is still at cycle 129.
- Undefined: every pixel is plotted, with bg for clear bits.

Test Plan:
1. Reset, then start with glyph of 'A', cell (0,0), fg=7, bg=0, ready=1 -> 128 plots in cycles 1..128. The row-1 pixels (3,1) and (4,1) have colour 7. Pixel (0,0) has colour 0. 16 pixels have colour 7 in total. done at cycle 129.
2. Cell (19,6), glyph all ones, fg=5 -> first pixel x=152, y=96; last pixel x=159, y=111; all colour 5.
3. Backpressure: toggle plot_ready 1,0,0,1 repeating -> no pixel skipped or duplicated, and x/y/colour are held while ready=0. 128 acceptances, then done.
4. Start with char_col=20, or with char_row=7 -> err pulses one cycle, busy stays 0, no plot.
5. Second start at pixel 50, then resetn=0 at pixel 60 -> the second start has no effect. After reset, all outputs are 0, no done, and a subsequent start draws normally.
6. With TRANSPARENT_BG_EN defined, glyph '.' -> exactly 2 plots, at (3,7) and (3,8) for cell (0,0), with done at cycle 129.
